// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer that owns the PC, IR and retired-instruction count.
// Optional macro CTRL_BRANCH_EN enables BEQ (op 0x4); without it op 0x4 is a NOP and zero is ignored.
module multicycle_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [31:0]      instr,
    input  logic             zero,
    output logic [4:0]       pc,
    output logic             EnIM,
    output logic [3:0]       rn1,
    output logic [3:0]       rn2,
    output logic [3:0]       wn,
    output logic             EnRW,
    output logic             ALUsrc,
    output logic [2:0]       ALUctrl,
    output logic             memread,
    output logic             memwrite,
    output logic             MemtoReg,
    output logic             busy,
    output logic             halted,
    output logic [CNT_W-1:0] retired,
    output logic [2:0]       dbg_state
);

`ifdef CTRL_BRANCH_EN
    localparam bit BRANCH_EN = 1'b1;
`else
    localparam bit BRANCH_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        K_NOP  = 3'd0,
        K_ALU  = 3'd1,
        K_LW   = 3'd2,
        K_SW   = 3'd3,
        K_BEQ  = 3'd4,
        K_HALT = 3'd5
    } kind_t;

    typedef struct packed {
        logic       en_im;
        logic       en_rw;
        logic       alu_src;
        logic [2:0] alu_ctrl;
        logic       mem_rd;
        logic       mem_wr;
        logic       mem_to_reg;
        logic       busy;
        logic       halted;
    } ctrl_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] ir;
    logic [31:0] ir_nx;
    kind_t       kind;
    kind_t       kind_nx;
    ctrl_t       ctrl_nx;
    logic        retire;
    logic        unused_imm;

    function automatic kind_t decode_kind(input logic [3:0] op);
        kind_t k;
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: k = K_ALU;
            4'h7:                   k = K_LW;
            4'h8:                   k = K_SW;
            4'h4:                   k = BRANCH_EN ? K_BEQ : K_NOP;
            4'hF:                   k = K_HALT;
            default:                k = K_NOP;
        endcase
        return k;
    endfunction

    // Outputs are a pure function of the state being entered, so they can be registered
    // alongside the state and still line up exactly with it.
    function automatic ctrl_t decode_ctrl(input state_t s, input logic [31:0] w, input kind_t k);
        ctrl_t c;
        c            = '0;
        c.en_im      = (s == S_FETCH);
        c.busy       = (s == S_FETCH) || (s == S_DECODE) || (s == S_EXEC) ||
                       (s == S_MEM) || (s == S_WB);
        c.halted     = (s == S_HALT);
        c.en_rw      = (s == S_WB);
        c.mem_to_reg = (s == S_WB) && (k != K_LW);
        c.mem_rd     = (k == K_LW) && ((s == S_MEM) || (s == S_WB));
        c.mem_wr     = (k == K_SW) && (s == S_MEM);
        if ((s == S_EXEC) || (s == S_MEM) || (s == S_WB)) begin
            case (w[31:28])
                4'h0: c.alu_ctrl = w[2:0];
                4'h1, 4'h7, 4'h8: begin
                    c.alu_src  = 1'b1;
                    c.alu_ctrl = 3'b010;
                end
                4'h2: begin
                    c.alu_src  = 1'b1;
                    c.alu_ctrl = 3'b000;
                end
                4'h3: begin
                    c.alu_src  = 1'b1;
                    c.alu_ctrl = 3'b001;
                end
                4'h4: c.alu_ctrl = BRANCH_EN ? 3'b110 : 3'b000;
                default: c.alu_ctrl = 3'b000;
            endcase
        end
        return c;
    endfunction

    assign kind    = decode_kind(ir[31:28]);
    assign kind_nx = decode_kind(ir_nx[31:28]);
    assign ctrl_nx = decode_ctrl(state_nx, ir_nx, kind_nx);

    always_comb begin
        state_nx = state;
        ir_nx    = ir;
        retire   = 1'b0;
        case (state)
            S_IDLE, S_HALT: if (start) state_nx = S_FETCH;
            S_FETCH: begin
                ir_nx    = instr;
                state_nx = S_DECODE;
            end
            S_DECODE: begin
                case (kind)
                    K_HALT: state_nx = S_HALT;
                    K_NOP: begin
                        state_nx = S_FETCH;
                        retire   = 1'b1;
                    end
                    default: state_nx = S_EXEC;
                endcase
            end
            S_EXEC: begin
                case (kind)
                    K_LW, K_SW: state_nx = S_MEM;
                    K_BEQ: begin
                        state_nx = S_FETCH;
                        retire   = 1'b1;
                    end
                    default: state_nx = S_WB;
                endcase
            end
            S_MEM: begin
                if (kind == K_LW) begin
                    state_nx = S_WB;
                end else begin
                    state_nx = S_FETCH;
                    retire   = 1'b1;
                end
            end
            S_WB: begin
                state_nx = S_FETCH;
                retire   = 1'b1;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            ir       <= '0;
            pc       <= '0;
            retired  <= '0;
            EnIM     <= 1'b0;
            EnRW     <= 1'b0;
            ALUsrc   <= 1'b0;
            ALUctrl  <= 3'b000;
            memread  <= 1'b0;
            memwrite <= 1'b0;
            MemtoReg <= 1'b0;
            busy     <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nx;
            ir       <= ir_nx;
            EnIM     <= ctrl_nx.en_im;
            EnRW     <= ctrl_nx.en_rw;
            ALUsrc   <= ctrl_nx.alu_src;
            ALUctrl  <= ctrl_nx.alu_ctrl;
            memread  <= ctrl_nx.mem_rd;
            memwrite <= ctrl_nx.mem_wr;
            MemtoReg <= ctrl_nx.mem_to_reg;
            busy     <= ctrl_nx.busy;
            halted   <= ctrl_nx.halted;

            // The branch target overrides the pc+4 already taken during FETCH.
            if (((state == S_IDLE) || (state == S_HALT)) && start)
                pc <= 5'd0;
            else if (state == S_FETCH)
                pc <= pc + 5'd4;
            else if ((state == S_EXEC) && (kind == K_BEQ) && zero)
                pc <= {ir[4:2], 2'b00};

            if ((state == S_IDLE) && start)
                retired <= '0;
            else if (retire)
                retired <= retired + CNT_W'(1);
        end
    end

    assign rn1        = ir[27:24];
    assign rn2        = ir[23:20];
    assign wn         = (ir[31:28] == 4'h0) ? ir[19:16] : ir[23:20];
    assign dbg_state  = state;
    assign unused_imm = ^ir[15:5];

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: an instruction-level trace model predicts every output on every
// busy cycle; literal checks pin reset, wrap, halt, async-abort and branch behaviour.
module tb_multicycle_ctrl;

`ifdef CTRL_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] instr;
    logic        zero_in;
    logic [4:0]  pc;
    logic        EnIM;
    logic [3:0]  rn1;
    logic [3:0]  rn2;
    logic [3:0]  wn;
    logic        EnRW;
    logic        ALUsrc;
    logic [2:0]  ALUctrl;
    logic        memread;
    logic        memwrite;
    logic        MemtoReg;
    logic        busy;
    logic        halted;
    logic [15:0] retired;
    logic [2:0]  dbg_state;

    logic [31:0] imem [8];
    logic [43:0] exp_q[$];
    logic [43:0] exp_v;
    logic [43:0] dut_vec;

    int n_total = 0;
    int n_bad   = 0;
    int n_push  = 0;
    int step    = 0;

    logic [4:0]  m_pc;
    logic [31:0] m_ir;
    logic [15:0] m_ret;

    multicycle_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .zero(zero_in),
        .pc(pc), .EnIM(EnIM), .rn1(rn1), .rn2(rn2), .wn(wn), .EnRW(EnRW),
        .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .memread(memread), .memwrite(memwrite),
        .MemtoReg(MemtoReg), .busy(busy), .halted(halted), .retired(retired),
        .dbg_state(dbg_state)
    );

    assign instr   = imem[pc[4:2]];
    assign dut_vec = {pc, EnIM, rn1, rn2, wn, EnRW, ALUsrc, ALUctrl,
                      memread, memwrite, MemtoReg, busy, halted, retired};

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    // scoreboard
    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            n_total++;
            if (dut_vec !== exp_v) begin
                n_bad++;
                $display("FAIL trace step %0d: got pc=%0d vec=%h want pc=%0d vec=%h",
                         step, dut_vec[43:39], dut_vec, exp_v[43:39], exp_v);
            end
            step++;
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // behavioural model
    function automatic logic [43:0] rec(input logic [4:0] p, input logic enim,
                                        input logic [31:0] w, input logic enrw,
                                        input logic [3:0] alu, input logic mr,
                                        input logic mw, input logic m2r, input logic bsy,
                                        input logic hlt, input logic [15:0] ret);
        logic [3:0] wreg;
        wreg = (w[31:28] == 4'h0) ? w[19:16] : w[23:20];
        return {p, enim, w[27:24], w[23:20], wreg, enrw, alu, mr, mw, m2r, bsy, hlt, ret};
    endfunction

    // {ALUsrc, ALUctrl} from the opcode table
    function automatic logic [3:0] alu_of(input logic [31:0] w);
        case (w[31:28])
            4'h0:       return {1'b0, w[2:0]};
            4'h1:       return 4'b1010;
            4'h2:       return 4'b1000;
            4'h3:       return 4'b1001;
            4'h7, 4'h8: return 4'b1010;
            4'h4:       return 4'b0110;
            default:    return 4'b0000;
        endcase
    endfunction

    function automatic void push(input logic [43:0] v);
        exp_q.push_back(v);
        n_push++;
    endfunction

    task automatic model_reset();
        m_pc  = 5'd0;
        m_ir  = 32'd0;
        m_ret = 16'd0;
    endtask

    task automatic model_run(input int n_instr, input bit from_idle);
        logic [31:0] w;
        logic [3:0]  op;
        logic [3:0]  alu;
        bit          is_alu;
        m_pc = 5'd0;
        if (from_idle) m_ret = 16'd0;
        for (int i = 0; i < n_instr; i++) begin
            w = imem[m_pc[4:2]];
            op = w[31:28];
            push(rec(m_pc, 1'b1, m_ir, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, m_ret));
            m_pc = m_pc + 5'd4;
            m_ir = w;
            push(rec(m_pc, 1'b0, m_ir, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, m_ret));
            if (op == 4'hF) begin
                push(rec(m_pc, 1'b0, m_ir, 1'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, m_ret));
                break;
            end
            is_alu = (op <= 4'h3);
            if (!(is_alu || op == 4'h7 || op == 4'h8 || (BR_EN && op == 4'h4))) begin
                m_ret = m_ret + 16'd1;
                continue;
            end
            alu = alu_of(w);
            push(rec(m_pc, 1'b0, m_ir, 1'b0, alu, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, m_ret));
            if (op == 4'h4) begin
                m_ret = m_ret + 16'd1;
                if (zero_in) m_pc = {w[4:2], 2'b00};
            end else if (op == 4'h7) begin
                push(rec(m_pc, 1'b0, m_ir, 1'b0, alu, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, m_ret));
                push(rec(m_pc, 1'b0, m_ir, 1'b1, alu, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, m_ret));
                m_ret = m_ret + 16'd1;
            end else if (op == 4'h8) begin
                push(rec(m_pc, 1'b0, m_ir, 1'b0, alu, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, m_ret));
                m_ret = m_ret + 16'd1;
            end else begin
                push(rec(m_pc, 1'b0, m_ir, 1'b1, alu, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, m_ret));
                m_ret = m_ret + 16'd1;
            end
        end
    endtask

    // driver tasks
    task automatic kick(input int n_instr, input bit from_idle);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        model_run(n_instr, from_idle);
    endtask

    task automatic drain(input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (exp_q.size() != 0) begin
            n_total++;
            n_bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // stimulus
    initial begin
        int base;
        rst     = 1'b1;
        start   = 1'b0;
        zero_in = 1'b0;
        for (int i = 0; i < 8; i++) imem[i] = 32'h5000_0000;
        model_reset();

        #12;
        chk("reset_pc", {27'd0, pc}, 32'd0);
        chk("reset_ctrl", {24'd0, EnIM, EnRW, ALUsrc, memread, memwrite, MemtoReg, busy, halted}, 32'd0);
        chk("reset_aluctrl", {29'd0, ALUctrl}, 32'd0);
        chk("reset_regs", {20'd0, rn1, rn2, wn}, 32'd0);
        chk("reset_retired", {16'd0, retired}, 32'd0);
        chk("reset_state", {29'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // AND, ADDI, LW, SW, HALT at pc=16
        imem[0] = 32'h0123_0000;
        imem[1] = 32'h1410_0007;
        imem[2] = 32'h7560_0010;
        imem[3] = 32'h8560_0010;
        imem[4] = 32'hF000_0000;
        base = n_push;
        kick(5, 1'b1);
        drain(100);
        chk("prog1_cycles", n_push - base, 32'd20);
        chk("prog1_halted", {31'd0, halted}, 32'd1);
        chk("prog1_busy", {31'd0, busy}, 32'd0);
        chk("prog1_retired", {16'd0, retired}, 32'd4);
        chk("prog1_pc", {27'd0, pc}, 32'd20);

        // restart from HALT, abort ADDI in WB with async reset
        kick(2, 1'b0);
        drain(50);
        chk("abort_wb_enrw", {31'd0, EnRW}, 32'd1);
        chk("abort_wb_retired", {16'd0, retired}, 32'd5);
        #1;
        rst = 1'b1;
        #1;
        chk("abort_enrw", {31'd0, EnRW}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_pc", {27'd0, pc}, 32'd0);
        chk("abort_state", {29'd0, dbg_state}, 32'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // eight NOPs wrap pc back to 0
        for (int i = 0; i < 8; i++) imem[i] = 32'h5000_0000;
        kick(8, 1'b1);
        drain(50);
        chk("wrap_pc_decode", {27'd0, pc}, 32'd0);
        chk("wrap_retired_decode", {16'd0, retired}, 32'd7);
        @(posedge clk);
        #1;
        chk("wrap_retired", {16'd0, retired}, 32'd8);
        chk("wrap_pc", {27'd0, pc}, 32'd0);
        chk("wrap_refetch", {31'd0, EnIM}, 32'd1);
        do_reset();

        // mixed program, start pulse while busy, HALT at pc=28
        imem[0] = 32'h0789_0006;
        imem[1] = 32'h2AB0_FFFF;
        imem[2] = 32'h3CD0_1234;
        imem[3] = 32'hE123_4567;
        imem[4] = 32'h8120_0004;
        imem[5] = 32'h7340_0008;
        imem[6] = 32'h0FED_0007;
        imem[7] = 32'hF000_0000;
        base = n_push;
        kick(8, 1'b1);
        repeat (5) @(negedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        drain(100);
        chk("prog3_cycles", n_push - base, 32'd30);
        chk("prog3_retired", {16'd0, retired}, 32'd7);
        chk("prog3_pc", {27'd0, pc}, 32'd0);
        chk("prog3_halted", {31'd0, halted}, 32'd1);

        // op 0x4 with imm=8, taken then not taken
        imem[0] = 32'h4000_0008;
        imem[1] = 32'h5000_0000;
        for (int i = 2; i < 8; i++) imem[i] = 32'hF000_0000;
        zero_in = 1'b1;
        base = n_push;
        kick(4, 1'b0);
        drain(50);
        chk("beq_z1_cycles", n_push - base, BR_EN ? 32'd6 : 32'd7);
        chk("beq_z1_retired", {16'd0, retired}, BR_EN ? 32'd8 : 32'd9);
        chk("beq_z1_pc", {27'd0, pc}, 32'd12);
        zero_in = 1'b0;
        base = n_push;
        kick(4, 1'b0);
        drain(50);
        chk("beq_z0_cycles", n_push - base, BR_EN ? 32'd8 : 32'd7);
        chk("beq_z0_retired", {16'd0, retired}, BR_EN ? 32'd10 : 32'd11);
        chk("beq_z0_halted", {31'd0, halted}, 32'd1);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the single-issue RISC datapath. It owns the 5-bit program counter and the instruction register, and steps each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK. It drives every enable and select of the datapath: imem enable, regfile read/write ports, ALU source and operation, data-memory read/write, and the write-back mux. It sits between a start/halt handshake from the testbench or top level and the datapath primitives.

## Interface
Parameters:
- CNT_W, 16, width of the retired-instruction counter

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin execution at pc=0; honoured in IDLE or HALT only
- instr  in  32  imem read data
- zero  in  1  ALU zero flag
- pc  out  5  imem byte address
- EnIM  out  1  imem enable
- rn1, rn2, wn  out  4 each  regfile read/write register numbers
- EnRW  out  1  regfile write enable
- ALUsrc  out  1  1 = sign-extended immediate, 0 = rd2
- ALUctrl  out  3  ALU operation
- memread, memwrite  out  1 each  data-memory strobes
- MemtoReg  out  1  1 = ALU result, 0 = memory data (mux polarity is fixed)
- busy  out  1  high in FETCH, DECODE, EXEC, MEM and WB
- halted  out  1  high in HALT
- retired  out  CNT_W  count of completed instructions; wraps modulo 2^CNT_W

## Operation
- IR fields: op=[31:28], rs=[27:24], rt=[23:20], rd=[19:16], imm=[15:0], funct=[2:0].
- rn1=IR.rs and rn2=IR.rt at all times. wn=IR.rd for op 0, otherwise IR.rt.
- Opcode map:
  - 0x0 R-type: ALUctrl=funct, ALUsrc=0.
  - 0x1 ADDI: ALUctrl=010.
  - 0x2 ANDI: ALUctrl=000.
  - 0x3 ORI: ALUctrl=001.
  - 0x7 LW: rt←mem[rs+imm].
  - 0x8 SW: mem[rs+imm]←rt.
  - 0x4 BEQ (see Configuration).
  - 0xF HALT.
  - All other opcodes are NOPs.
- ALUsrc=1 for ops 1, 2, 3, 7 and 8. ALUctrl=010 for LW/SW.
- States and transitions:
  - IDLE: start → FETCH.
  - FETCH: EnIM=1; IR←instr; pc←pc+4, 5-bit wrap (28+4=0). → DECODE.
  - DECODE: HALT → HALT state; NOP → FETCH; otherwise → EXEC.
  - EXEC: ALU ops → WB; LW/SW → MEM; BEQ → FETCH.
  - MEM: LW asserts memread and goes → WB. SW asserts memwrite and goes → FETCH.
  - WB: EnRW=1 → FETCH. MemtoReg=0 for LW, 1 otherwise.
  - HALT: start → FETCH with pc←0.
- memread stays high in both MEM and WB for LW, so read data is stable while the regfile writes.
- Any control output not listed for the current state is 0. The ALUctrl/ALUsrc decode is held from EXEC through WB.
- retired increments on leaving WB, on SW leaving MEM, on BEQ leaving EXEC, and on NOP leaving DECODE. HALT does not count.
- start is ignored while busy=1.
- From IDLE, start sets pc←0 and clears retired. From HALT, start sets pc←0 and retired is held.

## Timing
- Reset (async, immediate): state=IDLE; pc=0; IR=0; retired=0.
- Values of every output during reset: EnIM, EnRW, ALUsrc, ALUctrl, memread, memwrite, MemtoReg, busy and halted are all 0; rn1/rn2/wn=0.
- Latency per instruction (cycles from FETCH entry back to FETCH):
  - R-type/I-type: 4.
  - LW: 5.
  - SW: 4.
  - BEQ: 3.
  - NOP: 2.
  - HALT: 2 cycles to halted=1.
- EnRW is high for the full WB cycle. The regfile writes on the falling clock edge inside WB, so wn/MemtoReg/ALU inputs are stable from the preceding rising edge.
- memwrite is high for the full MEM cycle. The data memory captures on the rising edge that exits MEM.
- start is sampled on the rising edge. A one-cycle pulse is sufficient.
- rst asserted mid-instruction aborts immediately. No pending write completes, because EnRW/memwrite drop asynchronously.

## Configuration
- CTRL_BRANCH_EN defined:
  - op 0x4 BEQ: ALUctrl=110, ALUsrc=0 in EXEC.
  - If zero=1 at the end of EXEC, pc←{imm[4:2],2'b00}; otherwise pc is kept (already +4).
- CTRL_BRANCH_EN undefined: op 0x4 decodes as a NOP and zero is ignored.

## Test plan
- Reset then start; program word 0x0123_0000 (AND r3=r1&r2):
  - FETCH→DECODE→EXEC→WB.
  - EnRW=1 only in cycle 4, with wn=3, MemtoReg=1, ALUctrl=000.
  - retired=1 and pc=4.
- ADDI 0x1410_0007: ALUsrc=1, ALUctrl=010, wn=1 during WB.
- LW then SW at address rs+imm:
  - LW: memread is high for the MEM and WB cycles, MemtoReg=0 in WB, 5 cycles total.
  - SW: memwrite is high for exactly 1 cycle (MEM), EnRW never asserts, 4 cycles total.
- HALT 0xF000_0000 at pc=16:
  - halted=1 two cycles after FETCH, busy=0, retired is unchanged.
  - start then refetches at pc=0.
- PC wrap: 8 consecutive NOPs from pc=0 → pc returns to 0 after 16 cycles; retired=8.
- Async reset asserted during WB of an ADDI: EnRW drops to 0 without waiting for a clock edge, state=IDLE, pc=0.
- With CTRL_BRANCH_EN, BEQ with imm=0x0008:
  - zero=1 → next fetch at pc=8.
  - zero=0 → next fetch at pc+4.
  - Without the macro, the same word costs 2 cycles and the next fetch is at pc+4.
